// File: rtl/lcd_sync_rx_pkg.sv
// Shared timing definitions for the LTM panel receive path.
// Holds the nominal 800x480 geometry, counter saturation limits, the lock
// FSM state encoding (same values the sync generator side uses) and small
// saturating-increment helpers for the 11-bit and 10-bit counters.
package lcd_sync_rx_pkg;

  localparam logic [10:0] DEF_H_TOTAL     = 11'd1056;
  localparam logic [9:0]  DEF_V_TOTAL     = 10'd525;
  localparam logic [10:0] DEF_H_ACTIVE    = 11'd800;
  localparam logic [9:0]  DEF_V_ACTIVE    = 10'd480;
  localparam logic [3:0]  DEF_LOCK_FRAMES = 4'd2;

  localparam logic [10:0] H_SAT = 11'h7FF;
  localparam logic [9:0]  V_SAT = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == H_SAT) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == V_SAT) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/lcd_edge_det.sv
// Single-flop sampler with a registered falling-edge pulse for an
// active-low strobe.
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low reset
//   din   in  raw strobe, synchronous to clk
//   fall  out 1-cycle pulse, aligned with the cycle the low level is sampled
// The sample flop resets to 0, so a strobe that is already low when reset
// is released is not taken as an edge: the frame/line in progress is not
// treated as a fresh boundary.
module lcd_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic samp_q, samp_d;
  logic fall_q, fall_d;

  always_comb begin
    samp_d = din;
    fall_d = samp_q & ~din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      fall_q <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/lcd_sync_rx.sv
// Receive side of the LTM panel timing interface. Recovers pixel
// coordinates from the active-low HD/VD/DEN strobes, measures line and
// frame totals, verifies them against the expected geometry and reports
// lock and errors.
//   CLK, RST_n       pixel clock, asynchronous active-low reset
//   HD, VD, DEN      active-low line strobe, frame strobe, data enable
//   iCLR_ERR         clears oERR_STICKY (a same-cycle oERR wins)
//   oDE, oX, oY      data enable and pixel coordinates (x/y valid while oDE)
//   oSOF, oEOL       first pixel of frame, last pixel of line
//   oLOCKED          geometry verified for LOCK_FRAMES consecutive frames
//   oH_MEAS, oV_MEAS last measured line length (cycles) / frame length (lines)
//   oERR, oERR_STICKY mismatch pulse while locked, and its sticky copy
//   oSTATE           current lock FSM state (debug)
// Pipeline: stage 1 samples the strobes (edge detect for HD/VD), stage 2
// registers every output, so inputs reach the outputs 2 clocks later.
// oDE is a pure qualifier: no backpressure exists, and oX/oY/oSOF/oEOL are
// only meaningful in cycles where oDE is 1.
module lcd_sync_rx
  import lcd_sync_rx_pkg::*;
#(
  parameter logic [10:0] H_TOTAL     = DEF_H_TOTAL,
  parameter logic [9:0]  V_TOTAL     = DEF_V_TOTAL,
  parameter logic [10:0] H_ACTIVE    = DEF_H_ACTIVE,
  parameter logic [9:0]  V_ACTIVE    = DEF_V_ACTIVE,
  parameter logic [3:0]  LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        HD,
  input  logic        VD,
  input  logic        DEN,
  input  logic        iCLR_ERR,
  output logic        oDE,
  output logic [10:0] oX,
  output logic [9:0]  oY,
  output logic        oSOF,
  output logic        oEOL,
  output logic        oLOCKED,
  output logic [10:0] oH_MEAS,
  output logic [9:0]  oV_MEAS,
  output logic        oERR,
  output logic        oERR_STICKY,
  output logic [1:0]  oSTATE
);

  // ---------------- stage 1 ----------------
  logic hd_fall, vd_fall;
  logic den_s_q, den_s_d;

  lcd_edge_det u_hd_edge (.clk(CLK), .rst_n(RST_n), .din(HD), .fall(hd_fall));
  lcd_edge_det u_vd_edge (.clk(CLK), .rst_n(RST_n), .din(VD), .fall(vd_fall));

  // ---------------- stage 2 state ----------------
  rx_state_e   state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        line_den_q, line_den_d;   // current line has seen DEN low
  logic        frame_bad_q, frame_bad_d; // a line of this frame failed

  logic        de_q, de_d;
  logic [10:0] x_out_q, x_out_d;
  logic [9:0]  y_out_q, y_out_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;
  logic        locked_q, locked_d;
  logic [10:0] h_meas_q, h_meas_d;
  logic [9:0]  v_meas_q, v_meas_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;

  // ---------------- stage 2 combinational ----------------
  logic        den_act;
  logic [10:0] hcnt_meas;
  logic        line_bad;
  logic [10:0] x_base;
  logic [9:0]  y_line, vcnt_line, y_base;
  logic        frame_bad;
  logic        frame_good;

  always_comb begin
    den_s_d   = DEN;
    den_act   = ~den_s_q;
    hcnt_meas = sat_inc11(hcnt_q);

    // Closing line: wrong length, or a DEN line with the wrong pixel count.
    line_bad  = (hcnt_meas != H_TOTAL) | (line_den_q & (x_q != H_ACTIVE));

    // When HD and VD fall together the line is closed first (it counts in
    // vcnt/y of the frame being closed), then the frame is closed.
    x_base    = hd_fall ? 11'd0 : x_q;
    y_line    = (hd_fall & line_den_q) ? sat_inc10(y_q) : y_q;
    vcnt_line = hd_fall ? sat_inc10(vcnt_q) : vcnt_q;
    y_base    = vd_fall ? 10'd0 : y_line;

    frame_bad  = frame_bad_q | (hd_fall & line_bad);
    // Saturated counters can never equal the nominal totals, so the
    // equality tests also reject saturated frames.
    frame_good = ~frame_bad & (vcnt_line == V_TOTAL) & (y_line == V_ACTIVE);

    hcnt_d      = hd_fall ? 11'd0 : sat_inc11(hcnt_q);
    x_d         = den_act ? sat_inc11(x_base) : x_base;
    line_den_d  = den_act | (line_den_q & ~hd_fall);
    y_d         = y_base;
    vcnt_d      = vd_fall ? 10'd0 : vcnt_line;
    frame_bad_d = vd_fall ? 1'b0 : frame_bad;
    h_meas_d    = hd_fall ? hcnt_meas : h_meas_q;
    v_meas_d    = vd_fall ? vcnt_line : v_meas_q;

    // Lock FSM
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        // The frame in progress when searching starts is never trusted.
        if (vd_fall) begin
          state_d    = ST_CHECK;
          good_cnt_d = 4'd0;
        end
      end
      ST_CHECK: begin
        if (vd_fall) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 >= LOCK_FRAMES) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if ((hd_fall & line_bad) | (vd_fall & ~frame_good)) begin
          err_d   = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    // Output register inputs
    de_d     = den_act;
    x_out_d  = den_act ? x_base : 11'd0;
    y_out_d  = den_act ? y_base : 10'd0;
    sof_d    = den_act & (x_base == 11'd0) & (y_base == 10'd0);
    eol_d    = den_act & DEN;   // raw DEN is the next cycle's sample
    locked_d = (state_d == ST_LOCKED);
    sticky_d = err_q | (sticky_q & ~iCLR_ERR);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      den_s_q     <= 1'b1;
      state_q     <= ST_SEARCH;
      good_cnt_q  <= 4'd0;
      hcnt_q      <= 11'd0;
      vcnt_q      <= 10'd0;
      x_q         <= 11'd0;
      y_q         <= 10'd0;
      line_den_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      de_q        <= 1'b0;
      x_out_q     <= 11'd0;
      y_out_q     <= 10'd0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      locked_q    <= 1'b0;
      h_meas_q    <= 11'd0;
      v_meas_q    <= 10'd0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      den_s_q     <= den_s_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_den_q  <= line_den_d;
      frame_bad_q <= frame_bad_d;
      de_q        <= de_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      locked_q    <= locked_d;
      h_meas_q    <= h_meas_d;
      v_meas_q    <= v_meas_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign oDE         = de_q;
  assign oX          = x_out_q;
  assign oY          = y_out_q;
  assign oSOF        = sof_q;
  assign oEOL        = eol_q;
  assign oLOCKED     = locked_q;
  assign oH_MEAS     = h_meas_q;
  assign oV_MEAS     = v_meas_q;
  assign oERR        = err_q;
  assign oERR_STICKY = sticky_q;
  assign oSTATE      = state_q;

endmodule

// File: tb/tb_lcd_sync_rx.sv
// Testbench for lcd_sync_rx. Uses a scaled-down geometry (24 x 14 cycles,
// 10 x 8 active) so many frames fit in a short run; the receiver is
// parameterised with the same values. The sync generator drives inputs on
// the falling clock edge; outputs are sampled on the falling edge and
// belong to the input position driven two edges earlier (o_f/o_l/o_h).
module tb_lcd_sync_rx;

  localparam int HT = 24;
  localparam int HA = 10;
  localparam int VT = 14;
  localparam int VA = 8;
  localparam int H_DEN0   = 8;   // first DEN column
  localparam int V_DEN0   = 3;   // first DEN line
  localparam int VD_LINES = 2;   // VD low for lines 0..1
  localparam int BOUND    = 40000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hd = 1'b1, vd = 1'b1, den = 1'b1, clr = 1'b0;

  logic        o_de, o_sof, o_eol, o_locked, o_err, o_sticky;
  logic [10:0] o_x, o_hmeas;
  logic [9:0]  o_y, o_vmeas;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  lcd_sync_rx #(
    .H_TOTAL(11'(HT)), .V_TOTAL(10'(VT)), .H_ACTIVE(11'(HA)),
    .V_ACTIVE(10'(VA)), .LOCK_FRAMES(4'd2)
  ) dut (
    .CLK(clk), .RST_n(rst_n), .HD(hd), .VD(vd), .DEN(den), .iCLR_ERR(clr),
    .oDE(o_de), .oX(o_x), .oY(o_y), .oSOF(o_sof), .oEOL(o_eol),
    .oLOCKED(o_locked), .oH_MEAS(o_hmeas), .oV_MEAS(o_vmeas),
    .oERR(o_err), .oERR_STICKY(o_sticky), .oSTATE(o_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [10:0] exp_q[$];
  int q_frame = -1, q_line = -1;

  typedef struct {
    int         line;
    int         h;
    logic       de;
    logic [10:0] x;
    logic [9:0] y;
    logic       sof;
    logic       eol;
  } vec_t;
  vec_t tbl[12];
  bit   hit[12];
  int   tbl_frame = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_de"}, o_de, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_sof"}, o_sof, 0);
    check({tag, "_eol"}, o_eol, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_hmeas"}, o_hmeas, 0);
    check({tag, "_vmeas"}, o_vmeas, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_sticky"}, o_sticky, 0);
    check({tag, "_state"}, o_state, 0);
  endtask

  // ---------------- sync generator driver ----------------
  int g_f = 1, g_l = 0, g_h = 0;
  int p1_f = -1, p1_l = -1, p1_h = -1;
  int p2_f = -1, p2_l = -1, p2_h = -1;
  int o_f = -1, o_l = -1, o_h = -1;
  int ext_f = -1, ext_l = -1;          // line stretched by one cycle
  int vdoff_lo = -1, vdoff_hi = -1;    // frames whose VD pulse is suppressed

  task automatic table_check();
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].line == o_l && tbl[i].h == o_h) begin
        hit[i] = 1'b1;
        check($sformatf("tbl%0d_de", i), o_de, tbl[i].de);
        check($sformatf("tbl%0d_sof", i), o_sof, tbl[i].sof);
        check($sformatf("tbl%0d_eol", i), o_eol, tbl[i].eol);
        if (tbl[i].de) begin
          check($sformatf("tbl%0d_x", i), o_x, tbl[i].x);
          check($sformatf("tbl%0d_y", i), o_y, tbl[i].y);
        end
      end
    end
  endtask

  task automatic step();
    int len;
    @(negedge clk);
    o_f = p2_f; o_l = p2_l; o_h = p2_h;
    p2_f = p1_f; p2_l = p1_l; p2_h = p1_h;
    p1_f = g_f;  p1_l = g_l;  p1_h = g_h;
    hd  = (g_h != 0);
    vd  = !((g_l < VD_LINES) && !(g_f >= vdoff_lo && g_f < vdoff_hi));
    den = !(g_l >= V_DEN0 && g_l < V_DEN0 + VA && g_h >= H_DEN0 && g_h < H_DEN0 + HA);
    len = (g_f == ext_f && g_l == ext_l) ? HT + 1 : HT;
    g_h++;
    if (g_h >= len) begin
      g_h = 0;
      g_l++;
      if (g_l == VT) begin
        g_l = 0;
        g_f++;
      end
    end
    if (o_f == tbl_frame) table_check();
    if (o_f == q_frame && o_l == q_line && o_de === 1'b1) begin
      if (exp_q.size() == 0) check("q_extra_pixel", 1, 0);
      else check("q_x", o_x, exp_q.pop_front());
    end
  endtask

  task automatic run_to(input int f, input int l, input int h);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(o_f == f && o_l == l && o_h == h) && n < BOUND);
    if (!(o_f == f && o_l == l && o_h == h))
      check($sformatf("run_to_%0d_%0d_%0d_timeout", f, l, h), 1, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{3, 8, 1'b1, 11'd0, 10'd0, 1'b1, 1'b0};
    tbl[1]  = '{3, 9, 1'b1, 11'd1, 10'd0, 1'b0, 1'b0};
    tbl[2]  = '{3, 17, 1'b1, 11'd9, 10'd0, 1'b0, 1'b1};
    tbl[3]  = '{3, 18, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};
    tbl[4]  = '{4, 8, 1'b1, 11'd0, 10'd1, 1'b0, 1'b0};
    tbl[5]  = '{5, 12, 1'b1, 11'd4, 10'd2, 1'b0, 1'b0};
    tbl[6]  = '{10, 8, 1'b1, 11'd0, 10'd7, 1'b0, 1'b0};
    tbl[7]  = '{10, 17, 1'b1, 11'd9, 10'd7, 1'b0, 1'b1};
    tbl[8]  = '{0, 0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};
    tbl[9]  = '{2, 10, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};
    tbl[10] = '{3, 7, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};
    tbl[11] = '{11, 12, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_zero("rst");
    step();
    rst_n = 1'b1;   // released with frame 1 already started

    // 1: lock on the VD fall that ends frame 3
    run_to(3, VT - 1, HT - 1);
    check("t1_not_locked_yet", o_locked, 0);
    tbl_frame = 4;
    q_frame = 4;
    q_line = 5;
    for (int i = 0; i < HA; i++) exp_q.push_back(11'(i));
    run_to(4, 0, 0);
    check("t1_locked", o_locked, 1);
    check("t1_state", o_state, 2);
    check("t1_hmeas", o_hmeas, HT);
    check("t1_vmeas", o_vmeas, VT);

    // 2: coordinates across a locked frame (table + expected-x queue)
    run_to(5, 0, 0);
    for (int i = 0; i < 12; i++) check($sformatf("tbl%0d_hit", i), hit[i], 1);
    check("q_left", exp_q.size(), 0);
    tbl_frame = -1;

    // 3: one line stretched by a cycle while locked
    ext_f = 5;
    ext_l = 5;
    run_to(5, 5, HT);
    check("t3_pre_err", o_err, 0);
    check("t3_pre_locked", o_locked, 1);
    run_to(5, 6, 0);
    check("t3_err", o_err, 1);
    check("t3_unlocked", o_locked, 0);
    check("t3_hmeas", o_hmeas, HT + 1);
    step();
    check("t3_err_pulse_end", o_err, 0);
    check("t3_sticky", o_sticky, 1);
    run_to(7, VT - 1, HT - 1);
    check("t3_relock_early", o_locked, 0);
    run_to(8, 0, 0);
    check("t3_relock", o_locked, 1);

    // 4: clear vs. set in the same cycle
    clr = 1'b1;
    step();
    step();
    check("t4_cleared", o_sticky, 0);
    ext_f = 8;
    ext_l = 4;
    run_to(8, 5, 0);
    check("t4_err", o_err, 1);
    step();
    check("t4_set_wins", o_sticky, 1);
    step();
    check("t4_clear_alone", o_sticky, 0);
    clr = 1'b0;
    run_to(10, VT - 1, HT - 1);
    check("t4_relock_early", o_locked, 0);
    run_to(11, 0, 0);
    check("t4_relock", o_locked, 1);

    // 5: VD missing long enough for vcnt to saturate
    vdoff_lo = 12;
    vdoff_hi = 85;
    run_to(85, 0, 0);
    check("t5_vmeas_sat", o_vmeas, 1023);
    check("t5_err", o_err, 1);
    check("t5_unlocked", o_locked, 0);
    run_to(86, 0, 0);
    check("t5_vmeas_resume", o_vmeas, VT);
    check("t5_no_lock", o_locked, 0);
    run_to(87, VT - 1, HT - 1);
    check("t5_relock_early", o_locked, 0);
    run_to(88, 0, 0);
    check("t5_relock", o_locked, 1);

    // 6: reset in the middle of an active line
    run_to(88, 6, 12);
    check("t6_pre_de", o_de, 1);
    check("t6_pre_x", o_x, 4);
    check("t6_pre_y", o_y, 3);
    rst_n = 1'b0;
    #1 check_zero("t6_rst");
    repeat (3) step();
    rst_n = 1'b1;
    run_to(89, 3, 8);
    check("t6_de_unlocked", o_de, 1);
    check("t6_sof_unlocked", o_sof, 1);
    check("t6_x0", o_x, 0);
    check("t6_y0", o_y, 0);
    check("t6_not_locked", o_locked, 0);
    run_to(90, VT - 1, HT - 1);
    check("t6_relock_early", o_locked, 0);
    run_to(91, 0, 0);
    check("t6_relock", o_locked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
